// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if -- bundle of requester, FIFO-write and status signals
// for fifo_wr_arbiter.
//   req0/req1, data0/data1, last0/last1 : requester beats (request + data + end-of-burst)
//   ack0/ack1                           : per-requester beat accepted this cycle
//   fifo_full                           : downstream FIFO full flag
//   fifo_wr, fifo_wdata                 : write strobe / data into the downstream FIFO
//   owner, busy                         : index of locked requester / machine in LOCK
// Modports: slave = arbiter side, master = requester/FIFO environment side.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req0;
  logic                  req1;
  logic [DATA_WIDTH-1:0] data0;
  logic [DATA_WIDTH-1:0] data1;
  logic                  last0;
  logic                  last1;
  logic                  ack0;
  logic                  ack1;
  logic                  fifo_full;
  logic                  fifo_wr;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic                  owner;
  logic                  busy;

  modport slave (
    input  req0, req1, data0, data1, last0, last1, fifo_full,
    output ack0, ack1, fifo_wr, fifo_wdata, owner, busy
  );

  modport master (
    output req0, req1, data0, data1, last0, last1, fifo_full,
    input  ack0, ack1, fifo_wr, fifo_wdata, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter -- two-requester, burst-locking, round-robin write arbiter
// in front of a downstream FIFO.
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   bus        : fifo_wr_arbiter_if.slave (requesters, FIFO write port, owner/busy)
//   grant_cnt0 / grant_cnt1 : 16-bit saturating per-requester beat counters,
//                present only when FIFO_WR_ARB_STATS_EN is defined.
// Operation: in IDLE a winner is registered into owner (one cycle latency) and
// the machine locks onto it until a beat with last is written. The priority
// pointer then flips to the other requester.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  fifo_wr_arbiter_if.slave  bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_prio,  w_prio_nxt;   // requester preferred on contention
  logic [1:0] w_req, w_last, w_ack;
  logic       w_wr, w_win;

  assign w_req  = {bus.req1,  bus.req0};
  assign w_last = {bus.last1, bus.last0};

  // Pointer only matters when both request; otherwise the lone requester wins.
  assign w_win = (w_req == 2'b11) ? r_prio : w_req[1];

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_prio_nxt  = r_prio;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_state_nxt = S_LOCK;
          w_owner_nxt = w_win;
        end
      end
      S_LOCK: begin
        // Burst ends only on a beat that actually transferred with last set.
        if (w_wr && w_last[r_owner]) begin
          w_state_nxt = S_IDLE;
          w_prio_nxt  = ~r_owner;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // output logic
  always_comb begin
    w_wr  = 1'b0;
    w_ack = 2'b00;
    if (r_state == S_LOCK) begin
      w_wr           = w_req[r_owner] & ~bus.fifo_full;
      w_ack[r_owner] = w_wr;
    end
  end

  assign bus.fifo_wr    = w_wr;
  assign bus.ack0       = w_ack[0];
  assign bus.ack1       = w_ack[1];
  assign bus.fifo_wdata = r_owner ? bus.data1 : bus.data0;
  assign bus.owner      = r_owner;
  assign bus.busy       = (r_state == S_LOCK);

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        r_cnt <= '0;
      else if (w_ack[gi] && (r_cnt != 16'hFFFF))
        r_cnt <= r_cnt + 16'd1;
    end
  end
  assign grant_cnt0 = g_cnt[0].r_cnt;
  assign grant_cnt1 = g_cnt[1].r_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter -- scoreboard bench for fifo_wr_arbiter: directed
// scenarios followed by random requester/backpressure traffic, checked against
// a transaction-level model of burst locking and round-robin selection.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW)) bus ();
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  fifo_wr_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  typedef struct packed {
    logic          wr;
    logic          a0;
    logic          a1;
    logic          busy;
    logic          own;
    logic [DW-1:0] wd;
  } exp_t;

  typedef struct packed {
    logic          own;
    logic [DW-1:0] d;
  } beat_t;

  exp_t          cyc_q[$];
  beat_t         beat_q[$];
  logic [DW-1:0] log_d[$];
  int            log_c[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;

  // Model: is a burst locked, to whom, who is preferred next, beats per requester.
  bit m_busy, m_owner, m_pref;
  int m_beats[2];
  bit last_w, last_o;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, predict, push, then advance the model past the edge.
  task automatic step(input logic r0, input logic r1, input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1, input logic l0, input logic l1,
                      input logic full);
    exp_t  e;
    beat_t b;
    bit    o, w;
    bus.req0 = r0; bus.req1 = r1; bus.data0 = d0; bus.data1 = d1;
    bus.last0 = l0; bus.last1 = l1; bus.fifo_full = full;
    o = m_owner;
    w = m_busy && (o ? r1 : r0) && !full;
    e.wr = w; e.a0 = w && !o; e.a1 = w && o; e.busy = m_busy; e.own = o;
    e.wd = o ? d1 : d0;
    cyc_q.push_back(e);
    if (w) begin
      b.own = o; b.d = o ? d1 : d0;
      beat_q.push_back(b);
    end
    @(posedge clk);
    if (!m_busy) begin
      if (r0 || r1) begin
        m_owner = (r0 && r1) ? m_pref : r1;
        m_busy  = 1'b1;
      end
    end else if (w && (o ? l1 : l0)) begin
      m_busy = 1'b0;
      m_pref = !o;
    end
    if (w && m_beats[o] < 65535) m_beats[o]++;
    last_w = w; last_o = o;
    #1;
  endtask

  // Monitor: every cycle out of reset compare control outputs; every written beat
  // is matched against the expected beat stream.
  always @(negedge clk) begin
    exp_t  e;
    beat_t b;
    if (reset_n) begin
      cyc++;
      if (bus.fifo_wr) begin
        log_d.push_back(bus.fifo_wdata);
        log_c.push_back(cyc);
        if (beat_q.size() == 0) begin
          chk("unexpected_write", {23'd0, bus.owner, bus.fifo_wdata}, 32'hFFFF_FFFF);
        end else begin
          b = beat_q.pop_front();
          chk("beat", {23'd0, bus.owner, bus.fifo_wdata}, {23'd0, b});
        end
      end
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        chk("cycle", {19'd0, bus.fifo_wr, bus.ack0, bus.ack1, bus.busy, bus.owner,
                      bus.fifo_wdata}, {19'd0, e});
      end
    end
  end

  bit            pend[2];
  logic [DW-1:0] pd[2];
  bit            pl[2];
  bit            rq[2];

  initial begin
    reset_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.data0 = 0; bus.data1 = 0;
    bus.last0 = 0; bus.last1 = 0; bus.fifo_full = 0;
    m_busy = 0; m_owner = 0; m_pref = 0; m_beats[0] = 0; m_beats[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fifo_wr", {31'd0, bus.fifo_wr}, 32'd0);
    chk("rst_busy",    {31'd0, bus.busy},    32'd0);
    chk("rst_owner",   {31'd0, bus.owner},   32'd0);
    chk("rst_acks",    {30'd0, bus.ack1, bus.ack0}, 32'd0);
    @(negedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single beat from req0.
    step(1, 0, 8'h41, 8'h00, 1, 0, 0);
    step(1, 0, 8'h41, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 8'h00, 0, 0, 0);

    // req1 burst, reset asserted while its 2nd beat is presented.
    step(0, 1, 8'h00, 8'h20, 0, 0, 0);
    step(0, 1, 8'h00, 8'h20, 0, 0, 0);
    bus.data1 = 8'h21;
    #1 chk("pre_reset_wr", {31'd0, bus.fifo_wr}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_wr",   {31'd0, bus.fifo_wr}, 32'd0);
    chk("async_rst_ack",  {30'd0, bus.ack1, bus.ack0}, 32'd0);
    chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_rst_own",  {31'd0, bus.owner}, 32'd0);
    bus.req1 = 1'b0;
    m_busy = 0; m_owner = 0; m_pref = 0;
    @(negedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Contention after reset: both held with last=1 -> A0, B1, A0 spaced by 2.
    log_d.delete(); log_c.delete();
    repeat (6) step(1, 1, 8'hA0, 8'hB1, 1, 1, 0);
    step(0, 0, 8'h00, 8'h00, 0, 0, 0);
    chk("contend_cnt", log_d.size(), 32'd3);
    if (log_d.size() >= 3) begin
      chk("contend_d0", {24'd0, log_d[0]}, 32'hA0);
      chk("contend_d1", {24'd0, log_d[1]}, 32'hB1);
      chk("contend_d2", {24'd0, log_d[2]}, 32'hA0);
      chk("contend_gap01", log_c[1] - log_c[0], 32'd2);
      chk("contend_gap12", log_c[2] - log_c[1], 32'd2);
    end

    // Backpressure on owner 1 for 3 cycles.
    step(0, 1, 8'h00, 8'h55, 0, 1, 0);
    repeat (3) step(0, 1, 8'h00, 8'h55, 0, 1, 1);
    step(0, 1, 8'h00, 8'h55, 0, 1, 0);
    step(0, 0, 8'h00, 8'h00, 0, 0, 0);

    // req1 3-beat burst while req0 waits; req0 must win next.
    step(0, 1, 8'h77, 8'h10, 1, 0, 0);
    step(1, 1, 8'h77, 8'h10, 1, 0, 0);
    step(1, 1, 8'h77, 8'h11, 1, 0, 0);
    step(1, 1, 8'h77, 8'h12, 1, 1, 0);
    step(1, 1, 8'h77, 8'h99, 1, 1, 0);
    chk("lock_next_owner", {31'd0, bus.owner}, 32'd0);
    step(1, 1, 8'h77, 8'h99, 1, 1, 0);
    step(0, 0, 8'h00, 8'h00, 0, 0, 0);

    // Random traffic: beats held stable until acked, req may drop mid-burst.
    pend[0] = 0; pend[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(1, 0) == 1)) begin
          pend[i] = 1;
          pd[i]   = DW'($urandom);
          pl[i]   = ($urandom_range(2, 0) == 0);
        end
        rq[i] = pend[i] && ($urandom_range(4, 0) != 0);
      end
      step(rq[0], rq[1], pd[0], pd[1], pl[0], pl[1], $urandom_range(3, 0) == 0);
      if (last_w) pend[last_o] = 0;
    end
    step(0, 0, 8'h00, 8'h00, 0, 0, 0);

    chk("beats_drained", beat_q.size(), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("grant_cnt0", {16'd0, grant_cnt0}, m_beats[0]);
    chk("grant_cnt1", {16'd0, grant_cnt1}, m_beats[1]);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the requester data and FIFO write data.
REQ-002 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req0 / req1  input  1 each  requester N has a beat to write.
REQ-005 Port: data0 / data1  input  DATA_WIDTH each  requester N beat data.
REQ-006 Port: last0 / last1  input  1 each  current beat of requester N ends its burst.
REQ-007 Port: ack0 / ack1  output  1 each  beat of requester N accepted this cycle.
REQ-008 Port: fifo_full  input  1  downstream FIFO full flag.
REQ-009 Port: fifo_wr  output  1  write strobe to the downstream FIFO.
REQ-010 Port: fifo_wdata  output  DATA_WIDTH  write data to the downstream FIFO.
REQ-011 Port: owner  output  1  index of the requester holding the lock.
REQ-012 Port: busy  output  1  high while the state machine is in LOCK.

Function
REQ-013 The state machine SHALL have two states: IDLE and LOCK.
REQ-014 In IDLE with at least one req high, the block SHALL register the winner into owner and enter LOCK on the next edge, giving one cycle of arbitration latency.
REQ-015 Arbitration SHALL be round-robin: with both reqs high, the winner is the requester not served by the most recently completed burst; the priority pointer favors req0 after reset.
REQ-016 In IDLE, fifo_wr, ack0 and ack1 SHALL be 0, and no data SHALL be written.
REQ-017 In LOCK, fifo_wr SHALL equal req[owner] AND NOT fifo_full, combinationally.
REQ-018 In LOCK, ack[owner] SHALL equal fifo_wr, and ack of the non-owner SHALL be 0.
REQ-019 fifo_wdata SHALL equal data[owner] combinationally in every state.
REQ-020 A beat SHALL transfer exactly in a cycle where fifo_wr=1; the requester holds data and last stable until acked.
REQ-021 A transferred beat with last[owner]=1 SHALL return the machine to IDLE on the next edge and update the priority pointer to prefer the other requester.
REQ-022 If req[owner] drops in LOCK without a last beat, the machine SHALL stay in LOCK, with fifo_wr=0, until the owner resumes.
REQ-023 A non-owner req SHALL be ignored until the machine returns to IDLE; a burst is never interrupted.
REQ-024 While fifo_full=1 in LOCK, no write and no ack SHALL occur, and state and owner SHALL be held.
REQ-025 The minimum spacing between bursts SHALL be one IDLE cycle; back-to-back single-beat bursts yield one beat every 2 cycles.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, owner=0, busy=0, fifo_wr=0, ack0=ack1=0, and priority pointer to req0, regardless of clk.
REQ-027 A reset asserted mid-burst SHALL abandon the burst; after release, arbitration restarts from IDLE.

Configuration
REQ-028 Macro FIFO_WR_ARB_STATS_EN: when defined, outputs grant_cnt0 and grant_cnt1 (16 bits each) SHALL count transferred beats per requester, saturating at 0xFFFF and reset to 0 by reset_n.
REQ-029 When FIFO_WR_ARB_STATS_EN is undefined, the counters and ports SHALL be absent, and all other behavior SHALL be identical.

Verification
REQ-030 Single beat: after reset, req0=1, data0=0x41, last0=1 -> cycle 1 busy=1, owner=0, fifo_wr=1, fifo_wdata=0x41, ack0=1; next cycle busy=0.
REQ-031 Contention: req0 and req1 held high with last=1, data0=0xA0, data1=0xB1 -> writes alternate 0xA0, 0xB1, 0xA0, each separated by one IDLE cycle.
REQ-032 Backpressure: owner=1 in LOCK and fifo_full=1 for 3 cycles -> fifo_wr=0 and ack1=0 for 3 cycles; the held beat is written the cycle fifo_full drops.
REQ-033 Burst lock: req1 sends a 3-beat burst 0x10, 0x11, 0x12 (last on 0x12) while req0 is high -> req0 receives no ack until after 0x12, then wins the next arbitration.
REQ-034 Reset mid-burst: reset_n=0 during the 2nd beat -> fifo_wr, ack and busy are 0 with no clock edge; after release with both reqs high, owner=0.
REQ-035 Stats (macro defined): 4 single-beat bursts from req0 and 1 from req1 -> grant_cnt0=4, grant_cnt1=1; preloaded at 0xFFFF, one more beat leaves the count at 0xFFFF.
